// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, valid/ack byte handoff.
// Flags a low stop bit (FRAME_ERR) and a byte arriving while the previous one is unread (OVERRUN).
module uart_rx #(
  parameter int I_freq = 32000000,
  parameter int O_freq = 115200,
  parameter int OVS    = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA_OUT,
  output logic       RX_VALID,
  input  logic       RX_ACK,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int DIV_RAW = (I_freq + (O_freq * OVS) / 2) / (O_freq * OVS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = (OVS > 1) ? $clog2(OVS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   div_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            done;
  logic            tick;
  logic            mid_start;
  logic            bit_end;

  assign tick      = (div_cnt == CW'(DIV - 1));
  assign mid_start = tick && (tick_cnt == TW'(OVS / 2 - 1));
  assign bit_end   = tick && (tick_cnt == TW'(OVS - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      div_cnt   <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      done      <= 1'b0;
      DATA_OUT  <= 8'h00;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      rx_m      <= RX;
      rx_s      <= rx_m;
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      done      <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;

      // Delivery one cycle after the stop sample; an ack in that cycle frees the slot for the new byte.
      if (done) begin
        if (!RX_VALID) begin
          DATA_OUT <= shreg;
          RX_VALID <= 1'b1;
        end else if (RX_ACK) begin
          DATA_OUT <= shreg;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (RX_VALID && RX_ACK) begin
        RX_VALID <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (mid_start) begin
            tick_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (rx_s) done      <= 1'b1;
            else      FRAME_ERR <= 1'b1;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload register carries no reset; it is only observed after a complete frame.
  always_ff @(posedge CLK) begin
    if (state == DATA && bit_end) shreg[bit_idx] <= rx_s;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 64 clocks per bit: table of frames plus hand-written corner sequences.
// A background monitor pops expected bytes from a queue whenever the receiver delivers one.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX;
  logic       RX_ACK;
  logic [7:0] DATA_OUT;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       OVERRUN;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int ferr_cnt = 0;
  int deliv_cnt = 0;
  int deliv_cyc = 0;
  int frame_start = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       push;
    logic       ack;
    int         exp_ovr;
    int         exp_ferr;
    logic       exp_valid;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[5];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx #(.I_freq(6400), .O_freq(100), .OVS(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .RX(RX),
    .DATA_OUT(DATA_OUT),
    .RX_VALID(RX_VALID),
    .RX_ACK(RX_ACK),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN(OVERRUN)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic ack_pulse();
    RX_ACK = 1'b1;
    @(negedge CLK);
    RX_ACK = 1'b0;
    check("ack_clears_valid", RX_VALID, 0);
  endtask

  // Drives one frame from a falling clock edge; optionally acks late in the stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic ack_in_stop);
    frame_start = cyc;
    RX = 1'b0;
    repeat (BIT_CLK) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BIT_CLK) @(negedge CLK);
    end
    RX = stop;
    if (ack_in_stop) begin
      repeat (45) @(negedge CLK);
      ack_pulse();
      repeat (BIT_CLK - 46) @(negedge CLK);
    end else begin
      repeat (BIT_CLK) @(negedge CLK);
    end
    RX = 1'b1;
  endtask

  initial begin : monitor
    logic prev_v;
    logic ack_e;
    prev_v = 1'b0;
    forever begin
      @(posedge CLK);
      ack_e = RX_ACK;
      @(negedge CLK);
      if (RX_VALID && (!prev_v || ack_e)) begin
        deliv_cnt++;
        deliv_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery actual=%0h required=none", DATA_OUT);
        end else begin
          check("delivered_byte", DATA_OUT, exp_q.pop_front());
        end
      end
      if (OVERRUN)   ovr_cnt++;
      if (FRAME_ERR) ferr_cnt++;
      if (OVERRUN && FRAME_ERR) begin
        checks++;
        errors++;
        $display("FAIL flags_together actual=11 required=not both");
      end
      prev_v = RX_VALID;
    end
  end

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    int o0, f0, d0, lat;
    vecs[0] = '{data: 8'hA5, stop: 1'b1, push: 1'b1, ack: 1'b1, exp_ovr: 0, exp_ferr: 0, exp_valid: 1'b1, exp_dout: 8'hA5};
    vecs[1] = '{data: 8'h11, stop: 1'b1, push: 1'b1, ack: 1'b0, exp_ovr: 0, exp_ferr: 0, exp_valid: 1'b1, exp_dout: 8'h11};
    vecs[2] = '{data: 8'h22, stop: 1'b1, push: 1'b0, ack: 1'b1, exp_ovr: 1, exp_ferr: 0, exp_valid: 1'b1, exp_dout: 8'h11};
    vecs[3] = '{data: 8'h5A, stop: 1'b0, push: 1'b0, ack: 1'b0, exp_ovr: 0, exp_ferr: 1, exp_valid: 1'b0, exp_dout: 8'h11};
    vecs[4] = '{data: 8'h01, stop: 1'b1, push: 1'b1, ack: 1'b1, exp_ovr: 0, exp_ferr: 0, exp_valid: 1'b1, exp_dout: 8'h01};

    RST = 1'b0;
    RX = 1'b1;
    RX_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_valid", RX_VALID, 0);
    check("reset_dout", DATA_OUT, 8'h00);
    check("reset_ferr", FRAME_ERR, 0);
    check("reset_ovr", OVERRUN, 0);
    RST = 1'b1;
    repeat (10) @(negedge CLK);

    for (int v = 0; v < 5; v++) begin
      o0 = ovr_cnt;
      f0 = ferr_cnt;
      if (vecs[v].push) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, 1'b0);
      repeat (40) @(negedge CLK);
      if (vecs[v].push) begin
        lat = deliv_cyc - frame_start;
        checks++;
        if (lat < 606 || lat > 618) begin
          errors++;
          $display("FAIL latency_%0h actual=%0d required=606..618", vecs[v].data, lat);
        end
      end
      check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, vecs[v].exp_ovr);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_valid", v), RX_VALID, vecs[v].exp_valid);
      check($sformatf("vec%0d_dout", v), DATA_OUT, vecs[v].exp_dout);
      if (vecs[v].ack) ack_pulse();
      repeat (20) @(negedge CLK);
    end

    // Back-to-back frames, each acked shortly after delivery.
    o0 = ovr_cnt;
    d0 = deliv_cnt;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1);
    repeat (40) @(negedge CLK);
    check("b2b_deliveries", deliv_cnt - d0, 2);
    check("b2b_ovr", ovr_cnt - o0, 0);
    check("b2b_valid", RX_VALID, 0);
    check("b2b_dout", DATA_OUT, 8'hC3);

    // 20-clock low glitch on an idle line must be ignored.
    o0 = ovr_cnt;
    f0 = ferr_cnt;
    d0 = deliv_cnt;
    RX = 1'b0;
    repeat (20) @(negedge CLK);
    RX = 1'b1;
    repeat (100) @(negedge CLK);
    check("glitch_deliveries", deliv_cnt - d0, 0);
    check("glitch_flags", (ovr_cnt - o0) + (ferr_cnt - f0), 0);
    check("glitch_valid", RX_VALID, 0);
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    check("after_glitch_valid", RX_VALID, 1);
    check("after_glitch_dout", DATA_OUT, 8'hFF);
    ack_pulse();
    repeat (20) @(negedge CLK);

    // Asynchronous reset in the middle of data bit 4 of 8'h77.
    RX = 1'b0;
    repeat (BIT_CLK) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX = 1'b1 & (8'h77 >> i);
      repeat (BIT_CLK) @(negedge CLK);
    end
    RX = 1'b1;
    repeat (30) @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("async_rst_dout", DATA_OUT, 8'h00);
    check("async_rst_valid", RX_VALID, 0);
    check("async_rst_flags", {FRAME_ERR, OVERRUN}, 0);
    @(negedge CLK);
    RX = 1'b1;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    d0 = deliv_cnt;
    exp_q.push_back(8'h80);
    send_frame(8'h80, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    check("post_rst_deliveries", deliv_cnt - d0, 1);
    check("post_rst_dout", DATA_OUT, 8'h80);
    check("post_rst_valid", RX_VALID, 1);
    ack_pulse();
    repeat (10) @(negedge CLK);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
